// File: rtl/palindrome_serializer_if.sv
// Handshake bundle for palindrome_serializer: half-word input side plus serial output side.
// master = word source / serial sink, slave = the serializer.
interface palindrome_serializer_if #(
  parameter int BITS = 4
);
  localparam int HALF = (BITS + 1) / 2;

  logic            in_valid;
  logic            in_ready;
  logic [HALF-1:0] in_half;
  logic            out_bit;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;

  modport master (
    output in_valid, in_half, out_ready,
    input  in_ready, out_bit, out_valid, out_last, busy
  );

  modport slave (
    input  in_valid, in_half, out_ready,
    output in_ready, out_bit, out_valid, out_last, busy
  );
endinterface

// File: rtl/palindrome_serializer.sv
// Mirrors an accepted half-word into a BITS-bit palindrome and shifts it out MSB first.
// Optional gapless word-to-word streaming under `PAL_SER_BACK_TO_BACK_EN.
module palindrome_serializer #(
  parameter int BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  palindrome_serializer_if.slave  bus
);
  localparam int HALF  = (BITS + 1) / 2;
  localparam int CNT_W = $clog2(BITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BITS - 1);
  localparam logic [CNT_W-1:0] PENULT   = CNT_W'(BITS - 2);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q;
  logic [BITS-1:0]  sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_bit_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             busy_q;

  logic [BITS-1:0]  word_d;
  logic             in_ready_d;
  logic             accept;

  // Upper half is in_half as given; lower part repeats its leading bits in
  // reverse, so for odd BITS the middle bit in_half[0] appears only once.
  function automatic logic [BITS-1:0] mirror(input logic [HALF-1:0] h);
    logic [BITS-1:0] w;
    w = '0;
    for (int i = 0; i < HALF; i++) begin
      w[BITS-1-i] = h[HALF-1-i];
    end
    for (int j = 0; j < BITS - HALF; j++) begin
      w[j] = h[HALF-1-j];
    end
    return w;
  endfunction

  always_comb begin
    word_d = mirror(bus.in_half);
`ifdef PAL_SER_BACK_TO_BACK_EN
    in_ready_d = !reset &&
                 ((state_q == IDLE) ||
                  ((state_q == SEND) && (cnt_q == LAST_IDX) && bus.out_ready));
`else
    in_ready_d = !reset && (state_q == IDLE);
`endif
    accept = bus.in_valid && in_ready_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= SEND;
            sr_q        <= word_d;
            cnt_q       <= '0;
            out_bit_q   <= word_d[BITS-1];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (cnt_q == LAST_IDX) begin
              // Only reachable with back-to-back enabled: reload without an idle cycle.
              if (accept) begin
                sr_q        <= word_d;
                cnt_q       <= '0;
                out_bit_q   <= word_d[BITS-1];
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                busy_q      <= 1'b1;
              end else begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                out_bit_q   <= 1'b0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                busy_q      <= 1'b0;
              end
            end else begin
              sr_q       <= {sr_q[BITS-2:0], 1'b0};
              cnt_q      <= cnt_q + 1'b1;
              out_bit_q  <= sr_q[BITS-2];
              out_last_q <= (cnt_q == PENULT);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_palindrome_serializer.sv
// Drives a BITS=4 and a BITS=5 serializer with shared stimulus and checks both
// against a queue-of-bits transaction model.
module tb_palindrome_serializer;
`ifdef PAL_SER_BACK_TO_BACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 1'b0;
  logic       ordy = 1'b0;
  logic [2:0] h = 3'b000;

  always #5 clk = ~clk;

  palindrome_serializer_if #(.BITS(4)) if4 ();
  palindrome_serializer_if #(.BITS(5)) if5 ();

  assign if4.in_valid  = v;
  assign if4.in_half   = h[1:0];
  assign if4.out_ready = ordy;
  assign if5.in_valid  = v;
  assign if5.in_half   = h;
  assign if5.out_ready = ordy;

  palindrome_serializer #(.BITS(4)) u_dut4 (.clk(clk), .reset(rst), .bus(if4));
  palindrome_serializer #(.BITS(5)) u_dut5 (.clk(clk), .reset(rst), .bus(if5));

  logic o_rdy [2];
  logic o_bit [2];
  logic o_vld [2];
  logic o_last[2];
  logic o_busy[2];
  assign o_rdy[0]  = if4.in_ready;
  assign o_bit[0]  = if4.out_bit;
  assign o_vld[0]  = if4.out_valid;
  assign o_last[0] = if4.out_last;
  assign o_busy[0] = if4.busy;
  assign o_rdy[1]  = if5.in_ready;
  assign o_bit[1]  = if5.out_bit;
  assign o_vld[1]  = if5.out_valid;
  assign o_last[1] = if5.out_last;
  assign o_busy[1] = if5.busy;

  int          n_chk  = 0;
  int          n_pass = 0;
  bit          q [2][$];
  logic [31:0] got [2];
  int          ntk [2];
  int          nbusy [2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Palindrome as a bit list: the half-word MSB first, then its leading
  // (bits-half) entries in reverse order.
  function automatic void push_word(input int k, input logic [2:0] hh);
    int bits;
    int half;
    bit up[$];
    bits = (k == 0) ? 4 : 5;
    half = (bits + 1) / 2;
    for (int i = 0; i < half; i++) up.push_back(hh[half-1-i]);
    for (int i = 0; i < half; i++) q[k].push_back(up[i]);
    for (int i = bits - half - 1; i >= 0; i--) q[k].push_back(up[i]);
  endfunction

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      got[k]   = '0;
      ntk[k]   = 0;
      nbusy[k] = 0;
    end
  endtask

  // One clock: apply inputs after a negedge, check in_ready, step the model at
  // the posedge, then check the registered outputs at the following negedge.
  task automatic cycle(input logic iv, input logic [2:0] ih, input logic ior, input logic irst);
    logic erdy [2];
    v = iv; h = ih; ordy = ior; rst = irst;
    #1;
    for (int k = 0; k < 2; k++) begin
      erdy[k] = !irst && ((q[k].size() == 0) || (BTB && q[k].size() == 1 && ior));
      chk((k == 0) ? "in_ready4" : "in_ready5", {31'b0, o_rdy[k]}, {31'b0, erdy[k]});
      if (!irst && ior && o_vld[k]) begin
        got[k] = {got[k][30:0], o_bit[k]};
        ntk[k]++;
      end
      if (o_busy[k] === 1'b1) nbusy[k]++;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (irst) begin
        q[k].delete();
      end else begin
        if (q[k].size() > 0 && ior) void'(q[k].pop_front());
        if (iv && erdy[k]) push_word(k, ih);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk((k == 0) ? "out_valid4" : "out_valid5", {31'b0, o_vld[k]}, {31'b0, q[k].size() > 0});
      chk((k == 0) ? "out_last4" : "out_last5", {31'b0, o_last[k]}, {31'b0, q[k].size() == 1});
      chk((k == 0) ? "busy4" : "busy5", {31'b0, o_busy[k]}, {31'b0, q[k].size() > 0});
      if (q[k].size() > 0)
        chk((k == 0) ? "out_bit4" : "out_bit5", {31'b0, o_bit[k]}, {31'b0, q[k][0]});
      else if (irst)
        chk((k == 0) ? "rst_out_bit4" : "rst_out_bit5", {31'b0, o_bit[k]}, 32'd0);
    end
  endtask

  initial begin
    int span4;
    int span5;
    @(negedge clk);
    cycle(1'b0, 3'b000, 1'b0, 1'b1);
    cycle(1'b1, 3'b111, 1'b1, 1'b1);

    // Basic words: 4-bit 10 -> 1001, 5-bit 110 -> 11011
    clear_stats();
    cycle(1'b1, 3'b110, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'b000, 1'b1, 1'b0);
    chk("stream4_1001", got[0], 32'h9);
    chk("stream5_11011", got[1], 32'h1B);
    chk("busy4_cycles", nbusy[0], 32'd4);
    chk("busy5_cycles", nbusy[1], 32'd5);

    // Stall on bit index 1: 4-bit 01 -> 0110, 5-bit 001 -> 00100
    clear_stats();
    cycle(1'b1, 3'b001, 1'b1, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b111, 1'b0, 1'b0);
      chk("stall_bit4", {31'b0, o_bit[0]}, 32'd1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'b000, 1'b1, 1'b0);
    chk("stall_stream4", got[0], 32'h6);
    chk("stall_stream5", got[1], 32'h04);

    // Two words with in_valid held high
    clear_stats();
    span4 = 0;
    span5 = 0;
    cycle(1'b1, 3'b011, 1'b1, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      cycle(c <= 6, 3'b001, 1'b1, 1'b0);
      if (span4 == 0 && ntk[0] == 8) span4 = c;
      if (span5 == 0 && ntk[1] == 10) span5 = c;
    end
    chk("b2b_stream4", got[0], 32'hF6);
    chk("b2b_stream5", got[1], 32'h1C4);
    chk("b2b_span4", span4, BTB ? 32'd8 : 32'd9);
    chk("b2b_span5", span5, BTB ? 32'd10 : 32'd11);

    // Reset while bit index 2 is on the line
    clear_stats();
    cycle(1'b1, 3'b010, 1'b1, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 1'b1);
    chk("rst_mid_valid4", {31'b0, o_vld[0]}, 32'd0);
    chk("rst_mid_busy4", {31'b0, o_busy[0]}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'b000, 1'b1, 1'b0);
    chk("rst_mid_bits4", ntk[0], 32'd2);
    chk("rst_mid_got4", got[0], 32'h2);
    chk("rst_mid_got5", got[1], 32'h1);
    clear_stats();
    cycle(1'b1, 3'b110, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'b000, 1'b1, 1'b0);
    chk("post_rst_stream4", got[0], 32'h9);
    chk("post_rst_stream5", got[1], 32'h1B);

    // Random traffic, back-pressure and occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'b000, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/palindrome_serializer.md
# palindrome_serializer

- Transmit-side counterpart of the serial palindrome detector.
- Accepts a half-word on a valid/ready handshake and mirrors it into a BITS-bit palindrome.
- Shifts the palindrome out one bit per accepted cycle, MSB first, on a serial output with valid/ready flow control.
- Sits between a word source and any serial palindrome checker; used to drive detector benches and link loopback.

## Interface
- BITS, default 4: palindrome length in bits; legal range 2..32.
- HALF (localparam) = (BITS+1)/2: width of the input half-word.
- CNT_W (localparam) = $clog2(BITS): bit-index counter width.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_half holds a word to send.
- in_ready  output  1  block can accept a word this cycle.
- in_half  input  HALF  upper half of the palindrome, MSB = first bit transmitted.
- out_bit  output  1  current serial bit.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  sink takes out_bit this cycle.
- out_last  output  1  out_bit is the final bit (index 0) of the word.
- busy  output  1  a word is loaded and not fully transmitted.

## Operation
- Word construction at accept:
  - even BITS: word = {in_half, reverse(in_half)}.
  - odd BITS: word = {in_half, reverse(in_half[HALF-1:1])}; the middle bit is in_half[0], sent once.
- Accept occurs when in_valid && in_ready on a rising edge. in_half is captured into shift register sr[BITS-1:0]; counter cnt clears to 0.
- FSM states:
  - IDLE: out_valid=0, in_ready=1.
    - On accept -> SEND.
  - SEND: out_valid=1, out_bit=sr[BITS-1], out_last=(cnt==BITS-1).
    - On out_valid && out_ready with cnt<BITS-1: sr shifts left by one, cnt increments.
    - On out_ready with cnt==BITS-1: -> IDLE, unless a back-to-back accept occurs (see Configuration).
- Stall: with out_ready=0, out_bit, out_last, sr and cnt all hold.
- busy=1 exactly when in SEND.
- in_half is ignored unless an accept occurs; in_valid in SEND is ignored unless back-to-back is enabled.
- cnt never exceeds BITS-1; no wrap-around within a word.

## Timing
- Reset values (cycle after reset is sampled high): state=IDLE, sr=0, cnt=0, out_bit=0, out_valid=0, out_last=0, busy=0.
- in_ready is forced to 0 while reset=1 and is 1 on the first cycle after release.
- out_bit, out_valid, out_last and busy are registered. in_ready is combinational from state, cnt, out_ready and reset.
- Latency: accept at edge N -> first bit valid in cycle N+1.
- With out_ready held high, a word occupies BITS consecutive cycles.
- Without back-to-back: the last bit is taken at edge M, the cycle after M is IDLE, and the earliest next first bit is valid at M+2.
- Reset mid-word: the word is discarded at the next edge; all outputs return to reset values; no partial bits follow.

## Configuration
- PAL_SER_BACK_TO_BACK_EN:
  - Defined: in_ready is also 1 in SEND when cnt==BITS-1 && out_ready.
    - An accept on that edge loads the new word and stays in SEND with cnt=0.
    - The next word's first bit is valid the cycle immediately after the previous last bit (gapless stream).
  - Undefined: in_ready=1 only in IDLE; at least one idle cycle separates words.

## Test plan
- BITS=4, in_half=2'b10, out_ready=1 -> out_bit 1,0,0,1 on cycles N+1..N+4; out_last only on the 4th; then out_valid=0, in_ready=1.
- BITS=5, in_half=3'b110 -> stream 1,1,0,1,1 (middle bit sent once); busy high for exactly 5 cycles.
- BITS=4, in_half=2'b01, out_ready low for 3 cycles on bit index 1 -> out_bit=1 and cnt hold; stream completes as 0,1,1,0 with out_last on the final bit.
- Back-to-back with in_valid held high, words 2'b11 then 2'b01:
  - Macro defined -> 1,1,1,1,0,1,1,0 gapless.
  - Macro undefined -> one out_valid=0 cycle between the two words.
- Reset asserted one cycle during bit index 2 of word 2'b10 -> next cycle out_valid=0, busy=0, out_bit=0; no remaining bits emitted; a new accept then behaves as from power-up.
